// File: rtl/mod_counter.sv
// mod_counter: up/down counter with programmable step and modulus, load, and wrap/saturate limits
module mod_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              nE,
    input  logic              up,
    input  logic [STEP_W-1:0] step,
    input  logic              sat,
    input  logic [WIDTH-1:0]  modulus,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              wrapped,
    output logic              clipped
);
    localparam int E = WIDTH + 2;

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrapped_q, wrapped_d, clipped_q, clipped_d;
    logic [E-1:0]     c, m, st, s, r, dn, wu;

    assign c  = E'(count_q);
    assign m  = E'(modulus);
    assign st = E'(step);
    assign s  = c + st;
    assign r  = s - (m + 1'b1);
    assign dn = c - st;
    assign wu = c + m + 1'b1 - st;

    // next count and event flags; step 0 and M == 0 are handled ahead of the direction paths
    always_comb begin
        count_d   = count_q;
        wrapped_d = 1'b0;
        clipped_d = 1'b0;
        if (load) begin
            count_d = (load_val > modulus) ? modulus : load_val;
        end else if (!nE) begin
            if (step == '0) begin
                count_d   = (count_q > modulus) ? modulus : count_q;
                clipped_d = count_q > modulus;
            end else if (modulus == '0) begin
                count_d   = '0;
                wrapped_d = !sat;
                clipped_d = sat;
            end else if (up) begin
                if (s <= m) begin
                    count_d = WIDTH'(s);
                end else if (sat) begin
                    count_d   = modulus;
                    clipped_d = 1'b1;
                end else begin
                    count_d   = (r <= m) ? WIDTH'(r) : '0;
                    wrapped_d = 1'b1;
                end
            end else begin
                if (st <= c) begin
                    count_d   = (dn > m) ? modulus : WIDTH'(dn);
                    clipped_d = dn > m;
                end else if (sat) begin
                    count_d   = '0;
                    clipped_d = 1'b1;
                end else begin
                    count_d   = (st <= c + m + 1'b1) ? WIDTH'(wu) : modulus;
                    wrapped_d = 1'b1;
                end
            end
        end
    end

    // state register with synchronous reset
    always_ff @(posedge clk) begin
        if (Reset) begin
            count_q   <= '0;
            wrapped_q <= 1'b0;
            clipped_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
            clipped_q <= clipped_d;
        end
    end

    assign count   = count_q;
    assign wrapped = wrapped_q;
    assign clipped = clipped_q;
    assign tc      = (up && count_q == modulus) || (!up && count_q == '0);
endmodule
